cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 cache, combining datapath and control in one block.
- Sits between the lc3b pipeline memory port (16-bit words) and physical memory (128-bit lines).
- Generalises the existing 2-way datapath to any power-of-two way and set count.
- Replacement is tree pseudo-LRU; the block also maintains saturating hit and miss counters.

Parameters:
WAYS, 2, associativity; power of two, >= 2
SETS, 8, number of sets; power of two, >= 2
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  2  byte write mask (lc3b_mem_wmask)
mem_address  in  16  CPU byte address (lc3b_word)
mem_wdata  in  16  CPU write data
mem_rdata  out  16  read data; valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_address  out  16  line address; low 4 bits always 0
pmem_wdata  out  128  writeback line
pmem_rdata  in  128  fill line
pmem_resp  in  1  physical memory completion
hit_count  out  CNT_WIDTH  saturating count of hit completions
miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Address split:
  - offset = addr[3:0]; word = addr[3:1].
  - index = addr[4 +: log2(SETS)].
  - tag = remaining upper bits (16 - 4 - log2(SETS) bits).
- Per way/set storage: valid, dirty, tag, 128-bit data. Per set: WAYS-1 PLRU tree bits.
- Reset (reset=0, async):
  - All valid, dirty, PLRU and counter bits cleared; FSM to IDLE.
  - Outputs: mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0.
  - Data and tag arrays are not reset.
  - Reset mid-transaction aborts it. A pending pmem_resp after reset is ignored.
- FSM states: IDLE, RESP, WRITEBACK, ALLOCATE.
- IDLE:
  - No request: stay.
  - Request and hit (valid & tag match in some way): go to RESP.
  - On a write hit, in the same edge:
    - merge mem_wdata bytes selected by mem_byte_enable into the addressed word;
    - set dirty.
  - Request and miss: miss_count++ and select a victim:
    - lowest-index invalid way if any; otherwise the PLRU way.
    - Victim valid & dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
  - mem_read and mem_write both high: treat as write.
- RESP:
  - mem_resp=1 for exactly one cycle; mem_rdata = addressed word of the hit way (registered at IDLE exit).
  - Update that set's PLRU to point away from the accessed way; hit_count++.
  - Next state: IDLE. The requester may present a new request in the following cycle.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 4'b0}; pmem_wdata = victim line.
  - Outputs held stable until pmem_resp; then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1; pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: write the victim way with data = pmem_rdata, tag, valid=1, dirty=0; go to IDLE.
  - IDLE then re-evaluates and hits.
- Latency (edges from request seen in IDLE to mem_resp high):
  - hit: 1;
  - clean miss: fill latency + 2;
  - dirty miss: writeback + fill + 2.
- The retried access after a fill counts only as a hit; a miss therefore increments both miss_count and hit_count once each.
- Counters saturate at all-ones and do not wrap.
- PLRU is updated only in RESP, never on fill.
- pmem_read and pmem_write are never high together.
- mem_resp is never high outside RESP.

Test Plan:
- Reset, read 0x1234 -> ALLOCATE with pmem_address=0x1230; supply line with word2=0xBEEF; mem_resp with mem_rdata=0xBEEF; miss_count=1, hit_count=1.
- Write 0x1234 data 0xA5C3, byte_enable=2'b01 -> word becomes 0xBEC3; next read returns 0xBEC3 after one edge with no pmem activity.
- WAYS=4: fill five tags into the same set, accessing tags 0-3 in order -> the fifth evicts the PLRU way (way 0); dirty victim produces pmem_write at {old tag, index, 0} before pmem_read.
- Assert reset during ALLOCATE with pmem_read high -> pmem_read drops immediately; the next read of the same address misses again.
- Preload hit_count to saturation (CNT_WIDTH=4, 16 hits) -> hit_count stays 4'hF.
- mem_read and mem_write both high -> performs a write, single mem_resp pulse.

Source files
------------

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back L1 cache with tree PLRU and perf counters
// Single-block controller and datapath between the lc3b 16-bit memory port and 128-bit line memory.
module cache_nway #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           mem_byte_enable,
  input  logic [15:0]          mem_address,
  input  logic [15:0]          mem_wdata,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [15:0]          pmem_address,
  output logic [127:0]         pmem_wdata,
  input  logic [127:0]         pmem_rdata,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);
  localparam int WB = $clog2(WAYS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 12 - IB;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t               r_state;
  logic                 r_valid [WAYS][SETS];
  logic                 r_dirty [WAYS][SETS];
  logic [TB-1:0]        r_tag   [WAYS][SETS];
  logic [127:0]         r_data  [WAYS][SETS];
  logic [WAYS-2:0]      r_plru  [SETS];
  logic [WB-1:0]        r_way;
  logic [IB-1:0]        r_index;
  logic [15:0]          r_mem_rdata;
  logic                 r_mem_resp;
  logic                 r_pmem_read;
  logic                 r_pmem_write;
  logic [15:0]          r_pmem_address;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;

  logic [IB-1:0]   w_index;
  logic [TB-1:0]   w_tag;
  logic [2:0]      w_word;
  logic            w_req;
  logic            w_unused;
  logic [WAYS-1:0] w_way_hit;
  logic [WAYS-1:0] w_way_valid;
  logic            w_hit;
  logic [WB-1:0]   w_hit_way;
  logic [WB-1:0]   w_inv_way;
  logic            w_has_inv;
  logic [WB-1:0]   w_plru_way;
  logic [WB-1:0]   w_victim;
  logic [WAYS-2:0] w_plru_next;
  logic [127:0]    w_line;
  logic [15:0]     w_old_word;
  logic [15:0]     w_new_word;
  logic [127:0]    w_merged;

  assign w_index  = mem_address[4 +: IB];
  assign w_tag    = mem_address[15 -: TB];
  assign w_word   = mem_address[3:1];
  assign w_req    = mem_read | mem_write;
  assign w_unused = mem_address[0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_way_valid[g] = r_valid[g][w_index];
    assign w_way_hit[g]   = r_valid[g][w_index] && (r_tag[g][w_index] == w_tag);
  end

  assign w_hit = |w_way_hit;

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_way_hit[w[WB-1:0]]) w_hit_way = w[WB-1:0];
      if (!w_way_valid[w[WB-1:0]]) begin
        w_has_inv = 1'b1;
        w_inv_way = w[WB-1:0];
      end
    end
  end

  // Heap-ordered tree: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
  always_comb begin
    logic [WB-1:0] node;
    node       = '0;
    w_plru_way = '0;
    for (int l = 0; l < WB; l++) begin
      w_plru_way = WB'({w_plru_way, r_plru[w_index][node]});
      node       = WB'(2 * node + 1 + r_plru[w_index][node]);
    end
  end

  always_comb begin
    logic [WB-1:0] node;
    logic [WB-1:0] way;
    node        = '0;
    way         = r_way;
    w_plru_next = r_plru[r_index];
    for (int l = 0; l < WB; l++) begin
      w_plru_next[node] = ~way[WB-1];
      node              = WB'(2 * node + 1 + way[WB-1]);
      way               = way << 1;
    end
  end

  assign w_victim = w_has_inv ? w_inv_way : w_plru_way;

  always_comb begin
    w_line     = r_data[w_hit_way][w_index];
    w_old_word = w_line[{w_word, 4'b0} +: 16];
    w_new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : w_old_word[15:8],
                  mem_byte_enable[0] ? mem_wdata[7:0]  : w_old_word[7:0]};
    w_merged   = w_line;
    w_merged[{w_word, 4'b0} +: 16] = w_new_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_way          <= '0;
      r_index        <= '0;
      r_mem_rdata    <= '0;
      r_mem_resp     <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s[IB-1:0]] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[w[WB-1:0]][s[IB-1:0]] <= 1'b0;
          r_dirty[w[WB-1:0]][s[IB-1:0]] <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_index <= w_index;
            if (w_hit) begin
              r_way       <= w_hit_way;
              r_mem_rdata <= w_old_word;
              r_mem_resp  <= 1'b1;
              r_state     <= S_RESP;
              if (mem_write) r_dirty[w_hit_way][w_index] <= 1'b1;
            end else begin
              r_way <= w_victim;
              if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
              if (w_way_valid[w_victim] && r_dirty[w_victim][w_index]) begin
                r_pmem_write   <= 1'b1;
                r_pmem_address <= {r_tag[w_victim][w_index], w_index, 4'b0};
                r_state        <= S_WRITEBACK;
              end else begin
                r_pmem_read    <= 1'b1;
                r_pmem_address <= {mem_address[15:4], 4'b0};
                r_state        <= S_ALLOCATE;
              end
            end
          end
        end
        S_RESP: begin
          r_mem_resp      <= 1'b0;
          r_plru[r_index] <= w_plru_next;
          if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
          r_state         <= S_IDLE;
        end
        S_WRITEBACK: begin
          if (pmem_resp) begin
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= {mem_address[15:4], 4'b0};
            r_state        <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (pmem_resp) begin
            r_pmem_read             <= 1'b0;
            r_valid[r_way][r_index] <= 1'b1;
            r_dirty[r_way][r_index] <= 1'b0;
            r_state                 <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line and tag storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (r_state == S_ALLOCATE && pmem_resp) begin
      r_data[r_way][r_index] <= pmem_rdata;
      r_tag[r_way][r_index]  <= w_tag;
    end else if (r_state == S_IDLE && w_req && w_hit && mem_write) begin
      r_data[w_hit_way][w_index] <= w_merged;
    end
  end

  assign mem_rdata    = r_mem_rdata;
  assign mem_resp     = r_mem_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_data[r_way][r_index];
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - bench for cache_nway (4 ways, 8 sets, 4-bit counters)
// Reference model: per-way contents plus per-way last-use timestamps for pseudo-LRU.
module tb_cache_nway;
  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic [3:0]   hit_count, miss_count;

  int n_vec = 0;
  int n_err = 0;

  cache_nway #(.WAYS(4), .SETS(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  bit           m_valid [8][4];
  bit           m_dirty [8][4];
  logic [8:0]   m_tag   [8][4];
  logic [127:0] m_data  [8][4];
  int           m_ts    [8][4];
  int           m_now, m_hit, m_miss;
  logic [127:0] bmem [int];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [11:0] la);
    logic [127:0] l;
    if (!bmem.exists(int'(la))) begin
      for (int k = 0; k < 8; k++) l[k*16 +: 16] = 16'($urandom);
      bmem[int'(la)] = l;
    end
    return bmem[int'(la)];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_ts[s][w] = 0;
      end
    m_now = 0; m_hit = 0; m_miss = 0;
  endtask

  // Evict from the half not holding the most recent use, then the older way of that pair.
  function automatic int plru_victim(input int s);
    int mx, mxw, lo;
    mx = 0; mxw = -1;
    for (int w = 0; w < 4; w++) if (m_ts[s][w] > mx) begin mx = m_ts[s][w]; mxw = w; end
    lo = (mxw >= 0 && mxw < 2) ? 2 : 0;
    return (m_ts[s][lo] > m_ts[s][lo+1]) ? lo + 1 : lo;
  endfunction

  task automatic access(input logic [15:0] a, input bit wr, input bit rd_too,
                        input logic [1:0] be, input logic [15:0] wd,
                        output int lat, output int n_wb, output int n_fill,
                        output logic [15:0] rd, output logic [15:0] wb_addr);
    int s, hw, cyc, wait_c, pm_cyc;
    logic [8:0] tg;
    bit miss, exp_wb, busy, done;
    logic [15:0] exp_wb_addr, exp_rd, word;
    logic [127:0] exp_wb_data;
    s = int'(a[6:4]); tg = a[15:7]; hw = -1;
    exp_wb = 0; exp_wb_addr = '0; exp_wb_data = '0;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    miss = (hw < 0);
    if (miss) begin
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) hw = w;
      if (hw < 0) hw = plru_victim(s);
      if (m_valid[s][hw] && m_dirty[s][hw]) begin
        exp_wb = 1;
        exp_wb_addr = {m_tag[s][hw], a[6:4], 4'h0};
        exp_wb_data = m_data[s][hw];
        bmem[int'(exp_wb_addr[15:4])] = m_data[s][hw];
      end
      m_data[s][hw] = line_of(a[15:4]);
      m_valid[s][hw] = 1; m_dirty[s][hw] = 0; m_tag[s][hw] = tg;
      if (m_miss < 15) m_miss++;
    end
    if (m_hit < 15) m_hit++;
    m_now++; m_ts[s][hw] = m_now;
    word = m_data[s][hw][int'(a[3:1])*16 +: 16];
    exp_rd = word;
    if (wr) begin
      if (be[0]) word[7:0] = wd[7:0];
      if (be[1]) word[15:8] = wd[15:8];
      m_data[s][hw][int'(a[3:1])*16 +: 16] = word;
      m_dirty[s][hw] = 1;
    end

    @(negedge clk);
    mem_address = a; mem_write = wr; mem_read = !wr || rd_too;
    mem_byte_enable = be; mem_wdata = wd;
    lat = 0; n_wb = 0; n_fill = 0; rd = '0; wb_addr = '0;
    busy = 0; done = 0; cyc = 0; wait_c = 0; pm_cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      pmem_resp = 1'b0;
      check_eq("pmem_rw_exclusive", 128'(pmem_read & pmem_write), 128'(0));
      if (mem_resp) begin
        done = 1; lat = cyc; rd = mem_rdata;
        if (!wr) check_eq("rdata", 128'(mem_rdata), 128'(exp_rd));
      end else if (pmem_write || pmem_read) begin
        if (!busy) begin
          busy = 1; wait_c = $urandom_range(0, 3); pm_cyc += wait_c + 1;
          if (pmem_write) begin
            n_wb++; wb_addr = pmem_address;
            check_eq("wb_addr", 128'(pmem_address), 128'(exp_wb_addr));
            check_eq("wb_data", pmem_wdata, exp_wb_data);
            check_eq("wb_before_fill", 128'(n_fill), 128'(0));
          end else begin
            n_fill++;
            check_eq("fill_addr", 128'(pmem_address), 128'({a[15:4], 4'h0}));
          end
        end
        if (wait_c == 0) begin
          pmem_resp = 1'b1; busy = 0;
          pmem_rdata = pmem_read ? line_of(a[15:4]) : {4{$urandom}};
        end else wait_c--;
      end
    end
    if (!done) check_eq("timeout", 128'(0), 128'(1));
    mem_read = 0; mem_write = 0;
    @(posedge clk); #1;
    check_eq("resp_pulse", 128'(mem_resp), 128'(0));
    check_eq("n_wb", 128'(n_wb), 128'(exp_wb));
    check_eq("n_fill", 128'(n_fill), 128'(miss));
    if (done) check_eq("latency", 128'(lat), 128'(miss ? pm_cyc + 2 : 1));
    check_eq("hit_count", 128'(hit_count), 128'(m_hit));
    check_eq("miss_count", 128'(miss_count), 128'(m_miss));
  endtask

  int lat, nwb, nfill, k;
  logic [15:0] rd, wba, a;
  logic [127:0] l;
  logic [8:0] tg;

  initial begin
    reset = 0; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0; pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_resp", 128'(mem_resp), 128'(0));
    check_eq("rst_pmem_read", 128'(pmem_read), 128'(0));
    check_eq("rst_pmem_write", 128'(pmem_write), 128'(0));
    check_eq("rst_mem_rdata", 128'(mem_rdata), 128'(0));
    check_eq("rst_pmem_address", 128'(pmem_address), 128'(0));
    check_eq("rst_counts", 128'({hit_count, miss_count}), 128'(0));
    @(negedge clk) reset = 1;

    l = line_of(12'h123); l[47:32] = 16'hBEEF; bmem[int'(12'h123)] = l;
    access(16'h1234, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);
    check_eq("t1_rdata", 128'(rd), 128'(16'hBEEF));
    check_eq("t1_counts", 128'({hit_count, miss_count}), 128'({4'd1, 4'd1}));

    access(16'h1234, 1, 0, 2'b01, 16'hA5C3, lat, nwb, nfill, rd, wba);
    access(16'h1234, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);
    check_eq("t2_merged", 128'(rd), 128'(16'hBEC3));
    check_eq("t2_hit_latency", 128'(lat), 128'(1));

    for (int t = 0; t < 4; t++)
      access({9'h24 + 9'(t), 3'd3, 4'h2}, 1, 0, 2'b11, 16'(16'h1000 + t), lat, nwb, nfill, rd, wba);
    access({9'h30, 3'd3, 4'h6}, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);
    check_eq("t3_evict_way0", 128'(wba), 128'(16'h1230));
    check_eq("t3_wb_then_fill", 128'({nwb, nfill}), 128'({32'd1, 32'd1}));

    access(16'h0A5C, 1, 1, 2'b10, 16'h7E11, lat, nwb, nfill, rd, wba);
    access(16'h0A5C, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);

    @(negedge clk); mem_address = 16'h7F06; mem_read = 1;
    k = 0;
    while (!pmem_read && k < 20) begin @(posedge clk); #1; k++; end
    check_eq("t4_alloc_seen", 128'(pmem_read), 128'(1));
    #2 reset = 0;
    #1;
    check_eq("t4_pmem_read_drop", 128'(pmem_read), 128'(0));
    check_eq("t4_counts_clear", 128'({hit_count, miss_count}), 128'(0));
    mem_read = 0;
    @(negedge clk); reset = 1; pmem_resp = 1;
    @(posedge clk); #1; pmem_resp = 0;
    check_eq("t4_stale_resp", 128'({pmem_read, mem_resp}), 128'(0));
    model_reset();
    access(16'h7F06, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);
    check_eq("t4_miss_again", 128'(nfill), 128'(1));

    for (int t = 0; t < 20; t++)
      access(16'h0040, 0, 0, 2'b00, 16'h0, lat, nwb, nfill, rd, wba);
    check_eq("t5_hit_sat", 128'(hit_count), 128'(4'hF));

    for (int t = 0; t < 300; t++) begin
      tg = 9'($urandom_range(0, 5) * 37 + 3);
      a = {tg, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      access(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
             2'($urandom_range(0, 3)), 16'($urandom), lat, nwb, nfill, rd, wba);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
